// File: rtl/line_fetcher.sv
// line_fetcher
//   Fills the 1-bit x 512 line cache from the byte-wide video RAM. A fetch strobe
//   starts a line at mem_addrout; BYTES consecutive bytes are read (one read in
//   flight, one-byte hold buffer) and each byte is written into the cache MSB-first,
//   one bit per clock.
// Ports
//   pixel_clk, reset         : clock, asynchronous active-high reset
//   mem_addrout/readstrobe   : line start address and one-cycle fetch request
//   mem_ready                : idle, strobe will be accepted
//   ram_addr/ram_rd          : byte address and one-cycle read request
//   ram_valid/ram_data       : returned byte, valid for one cycle
//   cache_writeen/addrin/in  : cache bit write port
module line_fetcher #(
    parameter int unsigned BYTES = 32
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic [15:0] mem_addrout,
    input  logic        mem_readstrobe,
    output logic        mem_ready,
    output logic [15:0] ram_addr,
    output logic        ram_rd,
    input  logic        ram_valid,
    input  logic [7:0]  ram_data,
    output logic        cache_writeen,
    output logic [8:0]  cache_addrin,
    output logic        cache_in
);

    localparam logic [6:0] NBytes  = 7'(BYTES);
    localparam logic [8:0] LastBit = 9'(8 * BYTES - 1);

    typedef enum logic {StIdle, StFetch} state_t;

    state_t      r_state,    w_state_d;
    logic [15:0] r_ram_addr, w_ram_addr_d;
    logic        r_ram_rd,   w_ram_rd_d;
    logic        r_pending,  w_pending_d;   // one read outstanding
    logic [6:0]  r_issued,   w_issued_d;
    logic        r_hold_vld, w_hold_vld_d;
    logic [7:0]  r_hold,     w_hold_d;
    logic [6:0]  r_shift,    w_shift_d;     // remaining bits of current byte, MSB next
    logic [2:0]  r_left,     w_left_d;      // bits still to write from r_shift
    logic [8:0]  r_bit,      w_bit_d;       // next cache bit address
    logic        r_we,       w_we_d;
    logic        r_cin,      w_cin_d;
    logic [8:0]  r_caddr,    w_caddr_d;
    logic        w_accept;
    logic        w_direct;

    // A returned byte only counts while a read is actually in flight.
    assign w_accept = (r_state == StFetch) && r_pending && ram_valid;

    always_comb begin
        w_state_d    = r_state;
        w_ram_addr_d = r_ram_addr;
        w_ram_rd_d   = 1'b0;
        w_pending_d  = r_pending;
        w_issued_d   = r_issued;
        w_hold_vld_d = r_hold_vld;
        w_hold_d     = r_hold;
        w_shift_d    = r_shift;
        w_left_d     = r_left;
        w_bit_d      = r_bit;
        w_we_d       = 1'b0;
        w_cin_d      = r_cin;
        w_caddr_d    = r_caddr;
        w_direct     = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (mem_readstrobe) begin
                    w_ram_addr_d = mem_addrout;
                    w_ram_rd_d   = 1'b1;
                    w_pending_d  = 1'b1;
                    w_issued_d   = 7'd1;
                    w_bit_d      = 9'd0;
                    w_hold_vld_d = 1'b0;
                    w_left_d     = 3'd0;
                    w_state_d    = StFetch;
                end
            end
            StFetch: begin
                // Bit source priority: current byte, then hold buffer, then RAM bus.
                if (r_left != 3'd0) begin
                    w_we_d    = 1'b1;
                    w_cin_d   = r_shift[6];
                    w_shift_d = {r_shift[5:0], 1'b0};
                    w_left_d  = r_left - 3'd1;
                end else if (r_hold_vld) begin
                    w_we_d       = 1'b1;
                    w_cin_d      = r_hold[7];
                    w_shift_d    = r_hold[6:0];
                    w_left_d     = 3'd7;
                    w_hold_vld_d = 1'b0;
                end else if (w_accept) begin
                    w_direct  = 1'b1;
                    w_we_d    = 1'b1;
                    w_cin_d   = ram_data[7];
                    w_shift_d = ram_data[6:0];
                    w_left_d  = 3'd7;
                end

                if (w_we_d) begin
                    w_caddr_d = r_bit;
                    w_bit_d   = r_bit + 9'd1;
                end

                if (w_accept) begin
                    w_pending_d = 1'b0;
                    if (!w_direct) begin
                        w_hold_vld_d = 1'b1;
                        w_hold_d     = ram_data;
                    end
                end

                // Prefetch the next byte unless the hold buffer would stay full.
                if ((!r_pending || w_accept) && (r_issued < NBytes) && !w_hold_vld_d) begin
                    w_ram_rd_d   = 1'b1;
                    w_pending_d  = 1'b1;
                    w_issued_d   = r_issued + 7'd1;
                    w_ram_addr_d = r_ram_addr + 16'd1;
                end

                if (r_we && (r_caddr == LastBit)) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_ram_addr <= 16'd0;
            r_ram_rd   <= 1'b0;
            r_pending  <= 1'b0;
            r_issued   <= 7'd0;
            r_hold_vld <= 1'b0;
            r_hold     <= 8'd0;
            r_shift    <= 7'd0;
            r_left     <= 3'd0;
            r_bit      <= 9'd0;
            r_we       <= 1'b0;
            r_cin      <= 1'b0;
            r_caddr    <= 9'd0;
        end else begin
            r_state    <= w_state_d;
            r_ram_addr <= w_ram_addr_d;
            r_ram_rd   <= w_ram_rd_d;
            r_pending  <= w_pending_d;
            r_issued   <= w_issued_d;
            r_hold_vld <= w_hold_vld_d;
            r_hold     <= w_hold_d;
            r_shift    <= w_shift_d;
            r_left     <= w_left_d;
            r_bit      <= w_bit_d;
            r_we       <= w_we_d;
            r_cin      <= w_cin_d;
            r_caddr    <= w_caddr_d;
        end
    end

    assign mem_ready     = (r_state == StIdle);
    assign ram_addr      = r_ram_addr;
    assign ram_rd        = r_ram_rd;
    assign cache_writeen = r_we;
    assign cache_addrin  = r_caddr;
    assign cache_in      = r_cin;

endmodule

// File: tb/tb_line_fetcher.sv
// Bench for line_fetcher: instance 0 has BYTES=2, instance 1 has BYTES=32.
// Each instance has a latency-programmable RAM responder and a scoreboard that
// predicts the write stream, read addresses and mem_ready from the line rules.
module tb_line_fetcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst    [2];
    logic        strobe [2];
    logic [15:0] maddr  [2];
    logic        inj    [2];
    int          lat    [2];
    logic        ready  [2];
    logic [15:0] raddr  [2];
    logic        rd     [2];
    logic        we     [2];
    logic [8:0]  caddr  [2];
    logic        cin    [2];

    int          nrd      [2];
    int          nwr      [2];
    int          rd_total [2];
    int          wr_cyc   [2][512];
    logic        wr_bit   [2][512];
    logic [15:0] ra_log   [2][64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] mem(input logic [15:0] a);
        case (a)
            16'h0050: return 8'hA5;
            16'h0051: return 8'h3C;
            default:  return a[7:0] ^ a[15:8] ^ 8'h96;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int B = (g == 0) ? 2 : 32;
        logic        valid_l = 1'b0;
        logic [7:0]  data_l  = 8'h00;
        int          pend    = -1;
        logic [15:0] pa      = 16'h0;

        line_fetcher #(.BYTES(B)) dut (
            .pixel_clk      (clk),
            .reset          (rst[g]),
            .mem_addrout    (maddr[g]),
            .mem_readstrobe (strobe[g]),
            .mem_ready      (ready[g]),
            .ram_addr       (raddr[g]),
            .ram_rd         (rd[g]),
            .ram_valid      (valid_l),
            .ram_data       (data_l),
            .cache_writeen  (we[g]),
            .cache_addrin   (caddr[g]),
            .cache_in       (cin[g])
        );

        // RAM: a read seen after issue edge R is answered so the DUT samples it at R+lat.
        always @(negedge clk) begin
            valid_l = 1'b0;
            if (rst[g]) begin
                pend = -1;
            end else begin
                if (pend > 0) pend--;
                if (pend == 0) begin
                    valid_l = 1'b1; data_l = mem(pa); pend = -1;
                end
                if (rd[g]) begin
                    pa   = raddr[g];
                    pend = lat[g] - 1;
                    if (pend == 0) begin
                        valid_l = 1'b1; data_l = mem(pa); pend = -1;
                    end
                end
            end
            if (inj[g]) begin
                valid_l = 1'b1; data_l = 8'hFF;
            end
        end

        // Scoreboard
        logic        exp_ready = 1'b1;
        int          qaddr[$];
        logic        qbit[$];
        logic [15:0] qra[$];
        always @(negedge clk) begin
            logic       last;
            logic [7:0] by;
            logic [15:0] a;
            if (rst[g]) begin
                exp_ready = 1'b1;
                qaddr.delete(); qbit.delete(); qra.delete();
                chk("rst_ready", 32'(ready[g]), 32'd1);
                chk("rst_rd", 32'(rd[g]), 32'd0);
                chk("rst_we", 32'(we[g]), 32'd0);
            end else begin
                last = 1'b0;
                chk("mem_ready", 32'(ready[g]), 32'(exp_ready));
                if (rd[g]) begin
                    if (nrd[g] < 64) ra_log[g][nrd[g]] = raddr[g];
                    nrd[g]++;
                    rd_total[g]++;
                    if (qra.size() == 0) chk("extra_ram_rd", 32'd1, 32'd0);
                    else chk("ram_addr", 32'(raddr[g]), 32'(qra.pop_front()));
                end
                if (we[g]) begin
                    wr_cyc[g][caddr[g]] = cyc;
                    wr_bit[g][caddr[g]] = cin[g];
                    nwr[g]++;
                    if (qaddr.size() == 0) begin
                        chk("extra_write", 32'd1, 32'd0);
                    end else begin
                        chk("cache_addrin", 32'(caddr[g]), 32'(qaddr.pop_front()));
                        chk("cache_in", 32'(cin[g]), 32'(qbit.pop_front()));
                        last = (qaddr.size() == 0);
                    end
                end
                if (last) begin
                    exp_ready = 1'b1;
                    chk("rd_per_fetch", 32'(nrd[g]), 32'(B));
                end else if (strobe[g] && exp_ready) begin
                    exp_ready = 1'b0;
                    nrd[g] = 0;
                    nwr[g] = 0;
                    for (int n = 0; n < B; n++) begin
                        a  = maddr[g] + 16'(n);
                        by = mem(a);
                        qra.push_back(a);
                        for (int k = 0; k < 8; k++) begin
                            qaddr.push_back(8 * n + k);
                            qbit.push_back(by[7 - k]);
                        end
                    end
                end
            end
        end
    end

    int stb_cyc;

    task automatic pulse_strobe(input int g, input logic [15:0] a);
        maddr[g]  = a;
        strobe[g] = 1'b1;
        @(posedge clk); #1;
        strobe[g] = 1'b0;
        stb_cyc   = cyc;
    endtask

    task automatic wait_ready(input int g, input int budget);
        int n = 0;
        while (!ready[g] && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_timeout", 32'(ready[g]), 32'd1);
    endtask

    initial begin
        logic [15:0] p;
        int base;
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1; strobe[g] = 1'b0; maddr[g] = 16'h0; inj[g] = 1'b0; lat[g] = 1;
            nrd[g] = 0; nwr[g] = 0; rd_total[g] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 32'(ready[0]), 32'd1);
        chk("reset_raddr", 32'(raddr[0]), 32'd0);
        chk("reset_caddr", 32'(caddr[0]), 32'd0);
        chk("reset_cin", 32'(cin[0]), 32'd0);
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(posedge clk); #1;

        // Two bytes, latency 1.
        lat[0] = 1;
        pulse_strobe(0, 16'h0050);
        wait_ready(0, 100);
        for (int i = 0; i < 16; i++) p[15 - i] = wr_bit[0][i];
        chk("t1_bits", 32'(p), 32'h0000A53C);
        chk("t1_contig", 32'(wr_cyc[0][15] - wr_cyc[0][0]), 32'd15);
        chk("t1_first_lat", 32'(wr_cyc[0][0] - stb_cyc), 32'd1);
        chk("t1_ra0", 32'(ra_log[0][0]), 32'h0050);
        chk("t1_ra1", 32'(ra_log[0][1]), 32'h0051);
        chk("t1_nwr", 32'(nwr[0]), 32'd16);

        // Latency 12: gap between bytes.
        lat[0] = 12;
        pulse_strobe(0, 16'h0200);
        wait_ready(0, 200);
        chk("t3_first_lat", 32'(wr_cyc[0][0] - stb_cyc), 32'd12);
        chk("t3_gap", 32'(wr_cyc[0][8] - wr_cyc[0][7]), 32'd5);
        chk("t3_byte1_contig", 32'(wr_cyc[0][15] - wr_cyc[0][8]), 32'd7);

        // Address wrap.
        lat[0] = 2;
        pulse_strobe(0, 16'hFFFF);
        wait_ready(0, 100);
        chk("t4_ra0", 32'(ra_log[0][0]), 32'hFFFF);
        chk("t4_ra1", 32'(ra_log[0][1]), 32'h0000);

        // Strobe during FETCH is ignored.
        base = rd_total[0];
        pulse_strobe(0, 16'h0100);
        repeat (3) @(posedge clk);
        #1;
        pulse_strobe(0, 16'h0300);
        wait_ready(0, 100);
        repeat (10) @(posedge clk);
        #1;
        chk("t5_rd_count", 32'(rd_total[0] - base), 32'd2);
        chk("t5_nwr", 32'(nwr[0]), 32'd16);
        chk("t5_ready", 32'(ready[0]), 32'd1);

        // 32 bytes, latency 3.
        lat[1] = 3;
        pulse_strobe(1, 16'h1000);
        chk("t2_rd_t1", 32'(rd[1]), 32'd1);
        chk("t2_ready_t1", 32'(ready[1]), 32'd0);
        chk("t2_raddr_t1", 32'(raddr[1]), 32'h1000);
        @(posedge clk); #1;
        chk("t2_rd_t2", 32'(rd[1]), 32'd0);
        wait_ready(1, 2000);
        chk("t2_first_lat", 32'(wr_cyc[1][0] - stb_cyc), 32'd3);
        chk("t2_nwr", 32'(nwr[1]), 32'd256);
        chk("t2_contig", 32'(wr_cyc[1][255] - wr_cyc[1][0]), 32'd255);
        chk("t2_nrd", 32'(nrd[1]), 32'd32);

        // Reset in the middle of byte 5.
        pulse_strobe(1, 16'h2000);
        for (int i = 0; i < 500 && nwr[1] < 43; i++) @(posedge clk);
        chk("t6_reach_byte5", 32'(nwr[1] >= 43), 32'd1);
        @(posedge clk); #2;
        rst[1] = 1'b1;
        #1;
        chk("t6_async_ready", 32'(ready[1]), 32'd1);
        chk("t6_async_we", 32'(we[1]), 32'd0);
        chk("t6_async_rd", 32'(rd[1]), 32'd0);
        chk("t6_async_raddr", 32'(raddr[1]), 32'd0);
        chk("t6_async_caddr", 32'(caddr[1]), 32'd0);
        chk("t6_async_cin", 32'(cin[1]), 32'd0);
        @(posedge clk); #1;
        rst[1] = 1'b0;
        inj[1] = 1'b1;
        @(posedge clk); #1;
        inj[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_stray_we", 32'(we[1]), 32'd0);
        chk("t6_stray_ready", 32'(ready[1]), 32'd1);
        pulse_strobe(1, 16'h0000);
        wait_ready(1, 2000);
        chk("t6_refetch_nwr", 32'(nwr[1]), 32'd256);
        chk("t6_refetch_ra0", 32'(ra_log[1][0]), 32'h0000);
        chk("t6_refetch_ra31", 32'(ra_log[1][31]), 32'h001F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
